// File: rtl/fault_event_logger.sv
// Fault event logger: timestamps fault FSM state changes and major-fault onsets into a FWFT FIFO.
// Build option FAULT_LOG_MINOR_EN also logs rising edges of minor_fault.
module fault_event_logger #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               state_in,
    input  logic                     minor_fault,
    input  logic                     major_fault,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W+6:0]          evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned REC_W = TS_W + 7;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_WARNING  = 2'b01,
        ST_FAULT    = 2'b10,
        ST_SHUTDOWN = 2'b11
    } fault_state_t;

    logic [TS_W-1:0]  ts_q;
    logic [1:0]       last_state;
    logic             major_q;
    logic             minor_rise;
    logic [2:0]       cause;
    logic             event_det;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             overwrite;
    logic             ovf_evt;
    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] mem [DEPTH];
    logic [REC_W-1:0] hold_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;

`ifdef FAULT_LOG_MINOR_EN
    logic minor_q;

    always_ff @(posedge clk) begin
        if (rst) minor_q <= 1'b0;
        else     minor_q <= minor_fault;
    end

    assign minor_rise = minor_fault & ~minor_q;
`else
    logic unused_minor;

    assign unused_minor = minor_fault;
    assign minor_rise   = 1'b0;
`endif

    always_comb begin
        cause[0]  = (state_in != last_state);
        cause[1]  = major_fault & ~major_q;
        cause[2]  = minor_rise;
        event_det = |cause;
        empty     = (count_q == '0);
        full      = (count_q == (AW+1)'(DEPTH));
        pop       = ~empty & evt_ready;
        push      = event_det & (~full | pop);
        ovf_evt   = event_det & full & ~pop;
        // Shutdown entry must survive a full queue, so it replaces the newest record
        overwrite = ovf_evt & cause[0] & (state_in == ST_SHUTDOWN);
        rec       = {ts_q, last_state, state_in, cause};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            last_state <= ST_NORMAL;
            major_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            hold_q     <= '0;
        end else begin
            ts_q       <= ts_q + 1'b1;
            last_state <= state_in;
            major_q    <= major_fault;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr];
            end
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)           mem[wr_ptr]        <= rec;
        else if (overwrite) mem[wr_ptr - 1'b1] <= rec;
    end

    // Empty queue shows the last record handed out (zero after reset)
    assign evt_valid = ~empty;
    assign evt_data  = empty ? hold_q : mem[rd_ptr];
    assign evt_count = count_q;

endmodule

// File: tb/tb_fault_event_logger.sv
// Self-checking bench for fault_event_logger: reference model feeds a scoreboard queue checked on every pop.
module tb_fault_event_logger;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 16;
    localparam int unsigned REC_W = TS_W + 7;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       state_in = 2'b00;
    logic             minor_fault = 1'b0;
    logic             major_fault = 1'b0;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [REC_W-1:0] evt_data;
    logic [CW-1:0]    evt_count;
    logic             overflow;
    logic             clr_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [REC_W-1:0] sb [$];
    logic [TS_W-1:0]  m_ts;
    logic [1:0]       m_last;
    logic             m_maj;
    logic             m_min;
    logic             m_ovf;
    bit               known = 0;

    fault_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .state_in(state_in), .minor_fault(minor_fault),
        .major_fault(major_fault), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .evt_count(evt_count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One clock: check outputs against the model, advance the model, step to the next negedge
    task automatic cyc();
        logic [2:0]       c;
        logic [REC_W-1:0] r;
        logic [REC_W-1:0] e;
        bit               setovf;
        if (known) begin
            checks++;
            if (evt_count !== CW'(sb.size())) begin
                errors++;
                $display("FAIL count: got %0d expected %0d", evt_count, sb.size());
            end
            checks++;
            if (evt_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL valid: got %b expected %b", evt_valid, sb.size() != 0);
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL overflow: got %b expected %b", overflow, m_ovf);
            end
        end
        if (rst) begin
            sb.delete();
            m_ts = '0; m_last = 2'b00; m_maj = 1'b0; m_min = 1'b0; m_ovf = 1'b0;
            known = 1;
        end else begin
            if (sb.size() != 0 && evt_ready) begin
                e = sb.pop_front();
                checks++;
                if (evt_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", evt_data, e);
                end
            end
            c[0] = (state_in != m_last);
            c[1] = major_fault && !m_maj;
`ifdef FAULT_LOG_MINOR_EN
            c[2] = minor_fault && !m_min;
`else
            c[2] = 1'b0;
`endif
            setovf = 0;
            if (c != 3'b000) begin
                r = {m_ts, m_last, state_in, c};
                if (sb.size() < DEPTH) sb.push_back(r);
                else begin
                    setovf = 1;
                    if (c[0] && state_in == 2'b11) sb[sb.size()-1] = r;
                end
            end
            if (setovf) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_last = state_in; m_maj = major_fault; m_min = minor_fault;
            m_ts = m_ts + 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; state_in = 2'b00; major_fault = 1'b0; minor_fault = 1'b0;
        evt_ready = 1'b0; clr_ovf = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic fill_toggle(input int n);
        for (int i = 0; i < n; i++) begin
            state_in = (i % 2 == 0) ? 2'b01 : 2'b00;
            cyc();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (evt_valid !== 1'b0 || evt_count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b count=%0d ovf=%b expected 0 0 0", evt_valid, evt_count, overflow);
        end
        checks++;
        if (evt_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", evt_data);
        end
    endtask

    task automatic test_first_event();
        logic [REC_W-1:0] exp_rec;
        do_reset();
        repeat (5) cyc();
        state_in = 2'b01;
        cyc();
        exp_rec = {16'd5, 2'b00, 2'b01, 3'b001};
        checks++;
        if (evt_valid !== 1'b1 || evt_count !== CW'(1) || evt_data !== exp_rec) begin
            errors++;
            $display("FAIL first_event: got valid=%b count=%0d data=%h expected 1 1 %h", evt_valid, evt_count, evt_data, exp_rec);
        end
        evt_ready = 1'b1;
        cyc();
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || evt_data !== exp_rec) begin
            errors++;
            $display("FAIL empty_hold: got valid=%b data=%h expected 0 %h", evt_valid, evt_data, exp_rec);
        end
    endtask

    task automatic test_major();
        logic [REC_W-1:0] exp_rec;
        do_reset();
        state_in = 2'b10;
        cyc();
        repeat (19) cyc();
        major_fault = 1'b1;
        cyc();
        cyc();
        checks++;
        if (evt_count !== CW'(2)) begin
            errors++;
            $display("FAIL major_once: got count=%0d expected 2", evt_count);
        end
        evt_ready = 1'b1;
        cyc();
        exp_rec = {16'd20, 2'b10, 2'b10, 3'b010};
        checks++;
        if (evt_data !== exp_rec) begin
            errors++;
            $display("FAIL major_rec: got %h expected %h", evt_data, exp_rec);
        end
        cyc();
        evt_ready = 1'b0;
        major_fault = 1'b0;
    endtask

    task automatic test_overflow();
        logic [REC_W-1:0] exp_rec;
        do_reset();
        fill_toggle(9);
        exp_rec = {16'd0, 2'b00, 2'b01, 3'b001};
        checks++;
        if (evt_count !== CW'(DEPTH) || overflow !== 1'b1 || evt_data !== exp_rec) begin
            errors++;
            $display("FAIL ovf_full: got count=%0d ovf=%b head=%h expected 8 1 %h", evt_count, overflow, evt_data, exp_rec);
        end
        clr_ovf = 1'b1;
        state_in = 2'b00;
        cyc();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b expected 1", overflow);
        end
        clr_ovf = 1'b0;
        evt_ready = 1'b1;
        repeat (DEPTH) cyc();
        evt_ready = 1'b0;
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0 || evt_count !== '0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b count=%0d expected 0 0", overflow, evt_count);
        end
    endtask

    task automatic test_shutdown();
        logic [REC_W-1:0] exp_rec;
        do_reset();
        fill_toggle(DEPTH);
        state_in = 2'b11;
        cyc();
        checks++;
        if (evt_count !== CW'(DEPTH) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL shutdown_full: got count=%0d ovf=%b expected 8 1", evt_count, overflow);
        end
        evt_ready = 1'b1;
        repeat (DEPTH - 1) cyc();
        exp_rec = {16'd8, 2'b00, 2'b11, 3'b001};
        checks++;
        if (evt_data !== exp_rec) begin
            errors++;
            $display("FAIL shutdown_last: got %h expected %h", evt_data, exp_rec);
        end
        cyc();
        evt_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [REC_W-1:0] exp_rec;
        do_reset();
        fill_toggle(DEPTH);
        evt_ready = 1'b1;
        state_in = 2'b01;
        cyc();
        evt_ready = 1'b0;
        exp_rec = {16'd1, 2'b01, 2'b00, 3'b001};
        checks++;
        if (evt_count !== CW'(DEPTH) || overflow !== 1'b0 || evt_data !== exp_rec) begin
            errors++;
            $display("FAIL b2b_full: got count=%0d ovf=%b head=%h expected 8 0 %h", evt_count, overflow, evt_data, exp_rec);
        end
        evt_ready = 1'b1;
        repeat (DEPTH) cyc();
        evt_ready = 1'b0;
        checks++;
        if (evt_count !== '0) begin
            errors++;
            $display("FAIL b2b_drain: got count=%0d expected 0", evt_count);
        end
    endtask

    task automatic test_minor();
        do_reset();
        repeat (30) cyc();
        minor_fault = 1'b1;
        cyc();
        minor_fault = 1'b0;
        cyc();
`ifdef FAULT_LOG_MINOR_EN
        checks++;
        if (evt_count !== CW'(1) || evt_data !== {16'd30, 2'b00, 2'b00, 3'b100}) begin
            errors++;
            $display("FAIL minor_rec: got count=%0d data=%h expected 1 %h", evt_count, evt_data, {16'd30, 2'b00, 2'b00, 3'b100});
        end
`else
        checks++;
        if (evt_count !== '0) begin
            errors++;
            $display("FAIL minor_ignored: got count=%0d expected 0", evt_count);
        end
`endif
        evt_ready = 1'b1;
        cyc();
        evt_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        fill_toggle(3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (evt_count !== '0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got count=%0d valid=%b expected 0 0", evt_count, evt_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_event();
        test_major();
        test_overflow();
        test_shutdown();
        test_back_to_back();
        test_minor();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fault_event_logger.md
Name: fault_event_logger

Overview:
- Consumer side of the battery fault-detection interface.
- Watches the fault FSM outputs (state, minor_fault, major_fault) and timestamps every state change and major-fault onset.
- Queues each event as a record in a small FIFO, which a host or supervisor drains over a valid/ready handshake.
- The Shutdown entry is always recorded, even when the queue is full.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
TS_W, 16, timestamp counter width in bits
REC_W, TS_W+7, record width; derived, not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
state_in  in  2  fault FSM state: 00 Normal, 01 Warning, 10 Fault, 11 Shutdown
minor_fault  in  1  transient fault flag from the fault FSM
major_fault  in  1  persistent fault flag from the fault FSM
evt_valid  out  1  head record available
evt_ready  in  1  consumer accepts the head record
evt_data  out  REC_W  head record: {ts[TS_W-1:0], prev_state[1:0], new_state[1:0], cause[2:0]}
evt_count  out  $clog2(DEPTH)+1  number of entries held
overflow  out  1  sticky flag: an event was dropped
clr_ovf  in  1  clears overflow

Behaviour:
- Reset is synchronous and active-high on rst; single clock clk.
- Reset values:
  - ts counter = 0; last_state = 00; major_q = 0; minor_q = 0.
  - FIFO empty; evt_valid = 0; evt_count = 0; overflow = 0; evt_data = 0.
- Reset mid-operation discards all queued records.
- ts counter:
  - Increments every cycle and wraps modulo 2^TS_W.
  - A record carries the ts value sampled at the detecting edge, before increment.
- Event detection at each posedge (not in reset):
  - cause[0] = (state_in != last_state).
  - cause[1] = major_fault & !major_q.
  - cause[2] = 0 (see Optional Feature).
  - An event exists if any cause bit is set.
  - Record fields: prev_state = last_state, new_state = state_in.
  - last_state, major_q and minor_q update every cycle.
- Latency: an event detected at edge N gives evt_valid = 1 from edge N+1 when the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through: evt_data always shows the head whenever evt_valid = 1.
  - evt_data holds its last value when the FIFO is empty.
  - pop = evt_valid & evt_ready.
  - push is accepted when the FIFO is not full, or when pop occurs in the same cycle.
  - Simultaneous push and pop when full: both happen; evt_count stays DEPTH.
  - Simultaneous push and pop when empty: not possible, since the head is not yet valid. The push lands and evt_count becomes 1.
- Full with no pop:
  - If new_state = 11 and cause[0] = 1 (entry into Shutdown): the record overwrites the newest (tail-1) entry; overflow is set.
  - Otherwise the event is dropped; overflow is set.
- overflow:
  - Sticky.
  - Cleared by clr_ovf on the next edge, unless a drop or overwrite happens in the same cycle; set wins.
- Producer contract: the fault FSM holds Shutdown until reset. Once last_state = 11, no further cause[0] events occur unless state_in leaves 11, which is logged normally.
- evt_valid must not depend combinationally on evt_ready.

Optional Feature:
- Macro: FAULT_LOG_MINOR_EN.
- Defined: cause[2] = minor_fault & !minor_q; rising edges of the transient flag are logged as events, even when state is unchanged.
- Undefined: cause[2] is tied to 0; minor_q logic is removed; minor_fault is unused.
- Record width is identical in both builds.

Test Plan:
- Reset, then state_in 00->01 at cycle 5 -> at cycle 6: evt_valid = 1, evt_data = {ts=5, prev=00, new=01, cause=001}; evt_count = 1.
- state_in held at 10, major_fault rises at cycle 20 -> one record {ts=20, prev=10, new=10, cause=010}. The next cycle, with major_fault still high, produces no record.
- evt_ready = 0; generate 9 non-Shutdown events -> evt_count = 8, overflow = 1, and the first 8 records drain in order. Then clr_ovf = 1 -> overflow = 0.
- FIFO full, then state_in ->11 -> entry 8 is replaced by the Shutdown record, evt_count = 8, overflow = 1, and the last drained record has new = 11.
- FIFO full, with evt_ready = 1 and a new event in the same cycle -> head popped, new record appended, evt_count stays 8, overflow stays 0.
- With FAULT_LOG_MINOR_EN, state stays 00 and minor_fault pulses at cycle 30 -> record {ts=30, prev=00, new=00, cause=100}. Without the macro -> no record.
